// File: rtl/logicnet_lut_neuron_stream.sv
// logicnet_lut_neuron_stream: runtime-loadable truth-table neuron with a 2-stage valid/ready inference pipe.
// Table is distributed RAM written over a streaming load port; in_data addresses it directly.
module logicnet_lut_neuron_stream #(
    parameter int FAN_IN   = 3,
    parameter int IN_BITS  = 2,
    parameter int OUT_BITS = 2,
    localparam int ADDR_W  = FAN_IN * IN_BITS,
    localparam int DEPTH   = 2 ** ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_start,
    input  logic                load_valid,
    input  logic [OUT_BITS-1:0] load_data,
    output logic                load_ready,
    output logic                load_done,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_W-1:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_BITS-1:0] out_data,
    output logic                programmed
);
    localparam logic [1:0] EMPTY = 2'd0, LOAD = 2'd1, RUN = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d, wr_addr, s1_addr_q;
    logic                load_done_q, programmed_q, programmed_d;
    logic                s1_valid_q, out_valid_q;
    logic [OUT_BITS-1:0] out_data_q;
    logic [OUT_BITS-1:0] table_q [DEPTH];
    logic                pipe_en, pipe_empty, wr_en, last_wr, start_load;

    assign pipe_en    = !out_valid_q || out_ready;
    assign pipe_empty = !s1_valid_q && !out_valid_q;
    assign load_ready = state_q == LOAD;
    assign in_ready   = state_q == RUN && pipe_en;
    assign wr_en      = load_ready && load_valid;
    // A restart inside LOAD lets a same-cycle word land at entry 0.
    assign wr_addr    = load_start ? '0 : addr_q;
    assign last_wr    = wr_en && &wr_addr;
    assign start_load = load_start && (state_q == EMPTY ||
                        (state_q == RUN && pipe_empty && !load_done_q));

    always_comb begin
        state_d      = start_load ? LOAD : (last_wr ? RUN : state_q);
        addr_d       = load_ready ? wr_addr + ADDR_W'(wr_en) : '0;
        programmed_d = programmed_q || last_wr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= EMPTY;
            addr_q       <= '0;
            load_done_q  <= 1'b0;
            programmed_q <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_addr_q    <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            load_done_q  <= last_wr;
            programmed_q <= programmed_d;
            if (pipe_en) begin
                s1_valid_q  <= in_valid && in_ready;
                s1_addr_q   <= in_data;
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) out_data_q <= table_q[s1_addr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) table_q[wr_addr] <= load_data;
    end

    assign load_done  = load_done_q;
    assign programmed = programmed_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
endmodule

// File: tb/tb_logicnet_lut_neuron_stream.sv
// tb_logicnet_lut_neuron_stream: directed vector bench for the loadable LUT neuron.
module tb_logicnet_lut_neuron_stream;
    typedef struct {
        logic [5:0] addr;
        logic [1:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, load_start, load_valid, load_ready, load_done;
    logic [1:0] load_data;
    logic       in_valid, in_ready, out_valid, out_ready, programmed;
    logic [5:0] in_data;
    logic [1:0] out_data;

    int         tests = 0;
    int         fails = 0;
    vec_t       vt[8];
    logic [5:0] qa[$];
    logic [1:0] qe[$];

    logicnet_lut_neuron_stream dut (
        .clk(clk), .rst(rst),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .load_done(load_done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .programmed(programmed)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] wd(input int seq, input logic [5:0] a);
        return seq == 0 ? a[1:0] ^ a[5:4] : seq == 1 ? 2'b10 : seq == 2 ? a[3:2] : ~a[1:0];
    endfunction

    task automatic check_idle(input string nm);
        check({nm, "_out_valid"}, out_valid, 0);
        check({nm, "_load_ready"}, load_ready, 0);
        check({nm, "_load_done"}, load_done, 0);
        check({nm, "_programmed"}, programmed, 0);
        check({nm, "_in_ready"}, in_ready, 0);
        check({nm, "_out_data"}, out_data, 0);
    endtask

    task automatic load_seq(input int seq, input int lo, input int hi, input bit done_last);
        for (int a = lo; a <= hi; a++) begin
            load_valid = 1'b1;
            load_data  = wd(seq, 6'(a));
            check("load_ready", load_ready, 1);
            check("load_in_ready", in_ready, 0);
            tick;
            check("load_done", load_done, 32'(done_last && a == hi));
        end
        load_valid = 1'b0;
        load_data  = 2'b00;
    endtask

    task automatic push_vt(input int seq);
        for (int i = 0; i < 8; i++) begin
            qa.push_back(vt[i].addr);
            qe.push_back(seq == 0 ? vt[i].exp : wd(seq, vt[i].addr));
        end
    endtask

    task automatic stream(input string nm);
        int sent = 0, got = 0, cyc = 0, first_acc = -1, first_out = -1, prev = -1, gaps = 0;
        out_ready = 1'b1;
        while (got < qa.size() && cyc < 300) begin
            in_valid = sent < qa.size();
            in_data  = in_valid ? qa[sent] : 6'h00;
            if (in_valid && in_ready) begin
                if (first_acc < 0) first_acc = cyc;
                sent++;
            end
            tick;
            cyc++;
            if (out_valid) begin
                check({nm, "_data"}, out_data, qe[got]);
                if (first_out < 0) first_out = cyc;
                else if (prev != cyc - 1) gaps++;
                prev = cyc;
                got++;
            end
        end
        in_valid = 1'b0;
        check({nm, "_count"}, got, qa.size());
        check({nm, "_latency"}, first_out, first_acc + 2);
        check({nm, "_gaps"}, gaps, 0);
        tick;
        check({nm, "_drain"}, out_valid, 0);
        qa.delete();
        qe.delete();
    endtask

    initial begin
        vt[0] = '{6'h16, 2'b11};
        vt[1] = '{6'h2A, 2'b00};
        vt[2] = '{6'h3F, 2'b00};
        vt[3] = '{6'h00, 2'b00};
        vt[4] = '{6'h31, 2'b10};
        vt[5] = '{6'h05, 2'b01};
        vt[6] = '{6'h1C, 2'b01};
        vt[7] = '{6'h23, 2'b01};
        rst = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_data = 2'b00;
        in_valid = 1'b0; in_data = 6'h00; out_ready = 1'b1;
        tick;
        tick;
        check_idle("reset");
        rst = 1'b0;
        in_valid = 1'b1;
        in_data  = 6'h16;
        repeat (3) begin
            tick;
            check("idle_in_ready", in_ready, 0);
            check("idle_out_valid", out_valid, 0);
        end
        in_valid = 1'b0;

        load_start = 1'b1;
        tick;
        load_start = 1'b0;
        check("prog_before_load", programmed, 0);
        load_seq(0, 0, 63, 1'b1);
        check("prog_after_load", programmed, 1);
        load_start = 1'b1;
        tick;
        load_start = 1'b0;
        check("start_ignored_on_done", load_ready, 0);
        check("done_one_cycle", load_done, 0);

        for (int a = 0; a < 64; a++) begin
            qa.push_back(6'(a));
            qe.push_back(wd(0, 6'(a)));
        end
        stream("all64");
        push_vt(0);
        stream("vec_f");

        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 6'h16;
        check("bp_accept_a", in_ready, 1);
        tick;
        in_data = 6'h2A;
        check("bp_accept_b", in_ready, 1);
        tick;
        in_data = 6'h3F;
        repeat (5) begin
            check("bp_in_ready", in_ready, 0);
            tick;
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, 2'b11);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick;
        check("bp_next_valid", out_valid, 1);
        check("bp_next_data", out_data, 2'b00);
        tick;
        check("bp_drain", out_valid, 0);

        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 6'h05;
        tick;
        in_valid   = 1'b0;
        load_start = 1'b1;
        tick;
        check("rl_inflight_valid", out_valid, 1);
        check("rl_inflight_data", out_data, 2'b01);
        repeat (2) begin
            check("rl_ignored", load_ready, 0);
            tick;
        end
        out_ready = 1'b1;
        check("rl_busy", load_ready, 0);
        tick;
        check("rl_drained", out_valid, 0);
        check("rl_still_run", load_ready, 0);
        tick;
        check("rl_load", load_ready, 1);
        check("rl_prog_kept", programmed, 1);
        load_start = 1'b0;
        load_seq(1, 0, 63, 1'b1);
        push_vt(1);
        stream("vec_all10");

        load_start = 1'b1;
        tick;
        load_start = 1'b0;
        check("rs_load", load_ready, 1);
        load_seq(3, 0, 19, 1'b0);
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data  = wd(2, 6'h00);
        tick;
        load_start = 1'b0;
        check("rs_no_done", load_done, 0);
        load_seq(2, 1, 63, 1'b1);
        push_vt(2);
        stream("vec_restart");

        load_start = 1'b1;
        tick;
        load_start = 1'b0;
        load_seq(0, 0, 29, 1'b0);
        load_valid = 1'b1;
        load_data  = 2'b01;
        #2;
        rst = 1'b1;
        #1;
        check_idle("midreset");
        tick;
        rst = 1'b0;
        load_valid = 1'b0;
        in_valid   = 1'b1;
        in_data    = 6'h16;
        repeat (3) begin
            check("mr_in_ready", in_ready, 0);
            check("mr_programmed", programmed, 0);
            tick;
            check("mr_out_valid", out_valid, 0);
        end
        in_valid   = 1'b0;
        load_start = 1'b1;
        tick;
        load_start = 1'b0;
        load_seq(0, 0, 63, 1'b1);
        check("mr_reprogrammed", programmed, 1);
        check("mr_in_ready_run", in_ready, 1);
        push_vt(0);
        stream("vec_after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/logicnet_lut_neuron_stream.md
Name: logicnet_lut_neuron_stream

Overview:
- Next-generation LogicNet neuron: a parametrised truth-table neuron with FAN_IN inputs of IN_BITS each, producing an OUT_BITS output.
- Unlike the fixed combinational ROM neurons, the table is RAM-backed and loaded at runtime over a streaming load port, so one netlist serves any trained layer.
- Inference is a 2-stage registered pipeline with valid/ready handshakes.
- Sits between layer activation buffers in the layer datapath; the host or sequencer programs it before inference.

Parameters:
- FAN_IN, 3, number of neuron inputs.
- IN_BITS, 2, bits per input.
- OUT_BITS, 2, output activation width.
- ADDR_W, FAN_IN*IN_BITS (derived, not overridable), table address width.
- DEPTH, 2**ADDR_W (derived), table entries.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- load_start  in  1  begin (re)programming the table.
- load_valid  in  1  load_data is valid.
- load_data  in  OUT_BITS  table entry at the current load address.
- load_ready  out  1  load word accepted this cycle when high with load_valid.
- load_done  out  1  one-cycle pulse when the last entry is written.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  neuron accepts in_data.
- in_data  in  ADDR_W  concatenated inputs; input k is in_data[k*IN_BITS +: IN_BITS].
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  OUT_BITS  table[in_data] for the accepted input.
- programmed  out  1  table fully loaded at least once since reset.

Behaviour:
- Reset (async assert, sync release): state=EMPTY, load address=0. out_valid, load_ready, load_done, programmed, in_ready and pipeline valids all 0. out_data=0. Table contents are not reset.
- FSM states:
  - EMPTY: in_ready=0, load_ready=0.
  - LOAD: load_ready=1, in_ready=0.
  - RUN: in_ready=pipe_en, load_ready=0.
- FSM transitions:
  - EMPTY + load_start -> LOAD, addr=0.
  - LOAD: each load_valid cycle writes table[addr]=load_data and increments addr.
  - LOAD: the write at addr=DEPTH-1 -> RUN, load_done=1 for one cycle, programmed=1, addr wraps to 0.
  - LOAD + load_start (any cycle) -> addr restarts at 0, and any load_valid in that same cycle writes entry 0.
  - RUN + load_start: accepted only when both pipeline stages are empty; otherwise ignored, with no latching. The caller must hold load_start high.
  - Entering LOAD from RUN keeps programmed=1.
  - load_start is ignored in the cycle load_done pulses.
- Pipeline:
  - pipe_en = !out_valid || out_ready. pipe_en gates both stages.
  - Stage 1 registers in_data and in_valid&&in_ready.
  - Stage 2 reads the table at the stage-1 address and registers it into out_data and out_valid.
  - Latency: accept at cycle T -> out_valid at T+2. Throughput 1 result per cycle with out_ready held high.
- Backpressure: out_valid=1 && out_ready=0 freezes both stages. out_data holds stable; in_ready=0.
- Ordering: results emerge strictly in acceptance order; no drops, no duplicates.
- Pipeline flush: when out_ready=1 and in_valid=0, the stages drain (out_valid falls after the last result is taken).
- Reset mid-load or mid-inference: immediate return to EMPTY with programmed=0. Partially written table contents are undefined, and a full reload is required.
- Address/data width: in_data is used directly as the table address, with no arithmetic. Entries are OUT_BITS wide, stored verbatim.
- Implementation: the table is distributed RAM with a synchronous write and a read registered in stage 2.

Test Plan:
- Reset/idle: assert rst mid-cycle -> all outputs 0 immediately. After release, in_valid=1 gives in_ready=0 and no out_valid.
- Load and infer (defaults, DEPTH=64):
  - Load entry[a] = a[1:0]^a[5:4] (64 words, load_valid continuous) -> load_done pulses on the 64th accepted word, then programmed=1.
  - Stream all 64 inputs back-to-back -> outputs match entry[a]. First out_valid arrives 2 cycles after the first accept; 64 results arrive in 64 consecutive cycles.
- Backpressure:
  - Hold out_ready=0 for 5 cycles while streaming in_data=6'h16 then 6'h2A -> out_data stays 2'b11 (entry 6'h16), in_ready=0.
  - Release out_ready -> next results are 2'b00 for 6'h2A and then continue in order.
- Reload from RUN: raise load_start while results are in flight -> ignored until the pipe drains, then LOAD. Load all-2'b10 -> every subsequent input yields 2'b10.
- Restart mid-load: after 20 words, pulse load_start -> addr resets to 0. Exactly 64 further words are required before load_done; entries follow the second sequence.
- Reset mid-load at word 30 -> state EMPTY, programmed=0, in_ready stays 0 until a full 64-word reload completes.
